// File: rtl/note_lane_renderer.sv
// Note lane renderer: per-lane note shift registers advanced on a beat, then each lane box
// is drawn pixel by pixel to the VGA adapter. Optional macro NOTE_LANE_HIT_COLOUR_EN.
module note_lane_renderer #(
  parameter int unsigned LANES       = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned BOX_W       = 60,
  parameter int unsigned BOX_H       = 60,
  parameter int unsigned LANE_PITCH  = 60,
  parameter int unsigned ORIGIN_X    = 0,
  parameter int unsigned ORIGIN_Y    = 120,
  parameter logic [2:0]  NOTE_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_pattern,
  input  logic [LANES*DEPTH-1:0] pattern_in,
  input  logic                   shift_song,
  input  logic                   song_done,
  input  logic [LANES-1:0]       hit_in,
  input  logic                   plot_ready,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic [LANES-1:0]       current_notes,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   shift_overrun
);

  localparam int unsigned NW  = LANES * DEPTH;
  localparam int unsigned LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int unsigned PYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [2:0]  HIT_COLOUR = 3'b010;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

  state_e           state_q, state_d;
  logic [NW-1:0]    lanes_q, lanes_d;
  logic [LANES-1:0] cur_q, cur_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [PXW-1:0]   px_q, px_d;
  logic [PYW-1:0]   py_q, py_d;
  logic [8:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [2:0]       col_q, col_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NW-1:0]    shifted_c;
  logic [LANES-1:0] head_c;
  logic             beat_c;
  logic             do_shift_c;

`ifdef NOTE_LANE_HIT_COLOUR_EN
  logic [LANES-1:0] hit_q, hit_d;
`else
  logic             unused_hit;
  assign unused_hit = ^hit_in;
`endif

  // Per-lane one-slot advance: bit 0 leaves to the play line, zero enters at the top.
  always_comb begin
    shifted_c = '0;
    head_c    = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      shifted_c[i*DEPTH +: DEPTH] = lanes_q[i*DEPTH +: DEPTH] >> 1;
      head_c[i]                   = lanes_q[i*DEPTH];
    end
  end

  // A beat is ignored when a higher-priority control is active in the same cycle.
  assign beat_c = shift_song & ~load_pattern;

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    cur_d      = cur_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    lane_d     = lane_q;
    px_d       = px_q;
    py_d       = py_q;
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    do_shift_c = 1'b0;
`ifdef NOTE_LANE_HIT_COLOUR_EN
    hit_d      = hit_q;
`endif

    if (song_done) begin
      lanes_d   = '0;
      cur_d     = '0;
      pending_d = 1'b0;
      state_d   = IDLE;
      lane_d    = '0;
      px_d      = '0;
      py_d      = '0;
    end else begin
      if (load_pattern) lanes_d = pattern_in;

      unique case (state_q)
        IDLE: begin
          if (pending_q || beat_c) begin
            do_shift_c = 1'b1;
            pending_d  = pending_q & beat_c;
          end
        end
        DRAW: begin
          if (beat_c) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
          // Raster order inside a box: px fastest, then py, then lane.
          if (plot_q && plot_ready) begin
            if (px_q == PXW'(BOX_W - 1)) begin
              px_d = '0;
              if (py_q == PYW'(BOX_H - 1)) begin
                py_d = '0;
                if (lane_q == LW'(LANES - 1)) begin
                  lane_d  = '0;
                  state_d = DONE;
                end else begin
                  lane_d = lane_q + 1'b1;
                end
              end else begin
                py_d = py_q + 1'b1;
              end
            end else begin
              px_d = px_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (pending_q) begin
            do_shift_c = 1'b1;
            pending_d  = 1'b0;
            if (beat_c) overrun_d = 1'b1;
          end else begin
            state_d = IDLE;
            if (beat_c) pending_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (do_shift_c) begin
        cur_d = head_c;
        if (!load_pattern) lanes_d = shifted_c;
        state_d = DRAW;
        lane_d  = '0;
        px_d    = '0;
        py_d    = '0;
`ifdef NOTE_LANE_HIT_COLOUR_EN
        hit_d   = hit_in;
`endif
      end
    end

    // Pixel outputs are computed from the next counters so they are registered with them.
    if (state_d == DRAW) begin
      x_d   = 9'(ORIGIN_X + LANE_PITCH * 32'(lane_d) + 32'(px_d));
      y_d   = 8'(ORIGIN_Y + 32'(py_d));
      col_d = BG_COLOUR;
      if (cur_d[lane_d]) begin
`ifdef NOTE_LANE_HIT_COLOUR_EN
        col_d = hit_d[lane_d] ? HIT_COLOUR : NOTE_COLOUR;
`else
        col_d = NOTE_COLOUR;
`endif
      end
    end

    plot_d = (state_d == DRAW);
    busy_d = (state_d == DRAW);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lanes_q   <= '0;
      cur_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      lane_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lanes_q   <= lanes_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      lane_q    <= lane_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef NOTE_LANE_HIT_COLOUR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hit_q <= '0;
    else        hit_q <= hit_d;
  end
`endif

  assign vga_x         = x_q;
  assign vga_y         = y_q;
  assign vga_colour    = col_q;
  assign vga_plot      = plot_q;
  assign current_notes = cur_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign shift_overrun = overrun_q;

endmodule
